// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-stage signals exchanged between the datapath and the hazard unit.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW;
    logic mem_stall, excM;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW;
    logic div_busy, div_done;
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW,
        output mem_stall, excM,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, stallE, stallM, stallW,
        input  flushD, flushE, flushM, flushW, div_busy, div_done
    );
    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW,
        input  mem_stall, excM,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, stallE, stallM, stallW,
        output flushD, flushE, flushM, flushW, div_busy, div_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load/branch/divider stalls and exception flushes for a 5-stage pipeline.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int DIV_LAT = 32
) (
    input logic clk,
    input logic resetn,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} divStateT;
    localparam logic [REG_AW-1:0] zeroReg = '0;
    divStateT state, stateNext;
    logic [7:0] cnt, cntNext;
    logic lwStall, brStall, divStall, anyStall;
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] r);
        return (r != zeroReg && r == hz.writeregM && hz.regwriteM) ? 2'b10 :
               (r != zeroReg && r == hz.writeregW && hz.regwriteW) ? 2'b01 : 2'b00;
    endfunction
    assign hz.forwardaD = hz.rsD != zeroReg && hz.rsD == hz.writeregM && hz.regwriteM;
    assign hz.forwardbD = hz.rtD != zeroReg && hz.rtD == hz.writeregM && hz.regwriteM;
    assign hz.forwardaE = fwdSel(hz.rsE);
    assign hz.forwardbE = fwdSel(hz.rtE);
    assign lwStall = hz.memtoregE && hz.writeregE != zeroReg &&
                     (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
    assign brStall = hz.branchD &&
        ((hz.regwriteE && hz.writeregE != zeroReg && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
         (hz.memtoregM && hz.writeregM != zeroReg && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
    // The IDLE term lets the divide stall its first cycle without waiting for the state register.
    assign divStall = (state == IDLE && hz.divE) || state == BUSY;
    assign anyStall = lwStall || brStall || divStall || hz.mem_stall;
    assign hz.stallF = !hz.excM && anyStall;
    assign hz.stallD = !hz.excM && anyStall;
    assign hz.stallE = !hz.excM && (brStall || divStall || hz.mem_stall);
    assign hz.stallM = !hz.excM && hz.mem_stall;
    assign hz.stallW = !hz.excM && hz.mem_stall;
    assign hz.flushD = hz.excM;
    assign hz.flushE = hz.excM || ((lwStall || brStall) && !divStall && !hz.mem_stall);
    assign hz.flushM = hz.excM;
    assign hz.flushW = 1'b0;
    assign hz.div_busy = state == BUSY;
    assign hz.div_done = state == DONE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end
    // The counter ignores mem_stall so the divide latency is fixed in cycles.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (hz.excM) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: if (hz.divE) begin
                    stateNext = BUSY;
                    cntNext   = 8'(DIV_LAT - 1);
                end
                BUSY: begin
                    cntNext   = cnt <= 8'd1 ? 8'd0 : cnt - 8'd1;
                    stateNext = cnt <= 8'd1 ? DONE : BUSY;
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic checked against a cycle-count model of the hazard unit.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int DL = 4;
    logic clk = 0;
    logic resetn = 0;
    int checks = 0;
    int errors = 0;
    int busyLeft = 0;
    bit doneNow = 0;
    logic [16:0] actual;
    hazard_ctrl_if #(.REG_AW(AW)) hz();
    hazard_ctrl #(.REG_AW(AW), .DIV_LAT(DL)) dut (.clk(clk), .resetn(resetn), .hz(hz));
    always #5 clk = ~clk;
    assign actual = {hz.forwardaD, hz.forwardbD, hz.forwardaE, hz.forwardbE,
                     hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
                     hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.div_busy, hz.div_done};
    // Divider model: busyLeft counts the busy cycles still ahead, doneNow marks the result cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn || hz.excM) begin
            busyLeft <= 0;
            doneNow  <= 0;
        end else if (doneNow) doneNow <= 0;
        else if (busyLeft > 0) begin
            busyLeft <= busyLeft - 1;
            doneNow  <= busyLeft == 1;
        end else if (hz.divE) busyLeft <= DL - 1;
    end
    function automatic logic fwdD(input logic [AW-1:0] r);
        return r != 0 && r == hz.writeregM && hz.regwriteM;
    endfunction
    function automatic logic [1:0] fwdE(input logic [AW-1:0] r);
        if (r != 0 && r == hz.writeregM && hz.regwriteM) return 2'b10;
        if (r != 0 && r == hz.writeregW && hz.regwriteW) return 2'b01;
        return 2'b00;
    endfunction
    function automatic logic [16:0] expected();
        logic lw, br, dv, ms;
        logic [8:0] ctl;
        lw = hz.memtoregE && hz.writeregE != 0 && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
        br = hz.branchD && ((hz.regwriteE && hz.writeregE != 0 && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
                            (hz.memtoregM && hz.writeregM != 0 && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
        dv = busyLeft > 0 || (!doneNow && hz.divE);
        ms = hz.mem_stall;
        if (hz.excM) ctl = 9'b00000_1110;
        else ctl = {lw | br | dv | ms, lw | br | dv | ms, br | dv | ms, ms, ms, 1'b0, (lw | br) & !dv & !ms, 2'b00};
        return {fwdD(hz.rsD), fwdD(hz.rtD), fwdE(hz.rsE), fwdE(hz.rtE), ctl, busyLeft > 0, doneNow};
    endfunction
    task automatic clearInputs();
        {hz.rsD, hz.rtD, hz.rsE, hz.rtE, hz.writeregE, hz.writeregM, hz.writeregW} = '0;
        {hz.branchD, hz.regwriteE, hz.memtoregE, hz.divE, hz.regwriteM, hz.memtoregM, hz.regwriteW} = '0;
        hz.mem_stall = 0;
        hz.excM = 0;
    endtask
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        clearInputs();
        resetn = 0;
        @(negedge clk);
        checks++;
        if ({hz.div_busy, hz.div_done, hz.stallE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got busy/done/stallE %b expected 000", {hz.div_busy, hz.div_done, hz.stallE});
        end
        hz.divE = 1;
        #1;
        checks++;
        if (hz.stallE !== 1'b1 || hz.div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_divE: got stallE=%b busy=%b expected 1 0", hz.stallE, hz.div_busy);
        end
        clearInputs();
        nextCycle();
        resetn = 1;
        nextCycle();
    endtask
    task automatic test_forwarding();
        clearInputs();
        hz.rsE = 3; hz.writeregM = 3; hz.regwriteM = 1; hz.writeregW = 3; hz.regwriteW = 1;
        hz.rtE = 5; hz.rsD = 3;
        @(negedge clk);
        checks++;
        if (hz.forwardaE !== 2'b10) begin
            errors++;
            $display("FAIL fwdE_m_over_w: got %b expected 10", hz.forwardaE);
        end
        checks++;
        if (hz.forwardaD !== 1'b1) begin
            errors++;
            $display("FAIL fwdD_match: got %b expected 1", hz.forwardaD);
        end
        hz.writeregW = 5;
        #1;
        checks++;
        if (hz.forwardbE !== 2'b01) begin
            errors++;
            $display("FAIL fwdE_w: got %b expected 01", hz.forwardbE);
        end
        hz.rsE = 0; hz.rsD = 0; hz.writeregM = 0; hz.writeregW = 0;
        #1;
        checks++;
        if ({hz.forwardaE, hz.forwardaD} !== 3'b000) begin
            errors++;
            $display("FAIL fwd_r0: got %b expected 000", {hz.forwardaE, hz.forwardaD});
        end
        nextCycle();
    endtask
    task automatic test_lwstall();
        clearInputs();
        hz.memtoregE = 1; hz.writeregE = 7; hz.rtD = 7;
        @(negedge clk);
        checks++;
        if ({hz.stallF, hz.stallD, hz.flushE, hz.stallE} !== 4'b1110) begin
            errors++;
            $display("FAIL lwstall: got F/D/flushE/E %b expected 1110", {hz.stallF, hz.stallD, hz.flushE, hz.stallE});
        end
        hz.writeregE = 0; hz.rtD = 0;
        #1;
        checks++;
        if ({hz.stallF, hz.stallD, hz.flushE, hz.stallE} !== 4'b0000) begin
            errors++;
            $display("FAIL lwstall_r0: got %b expected 0000", {hz.stallF, hz.stallD, hz.flushE, hz.stallE});
        end
        nextCycle();
    endtask
    task automatic test_div_sequence();
        clearInputs();
        hz.divE = 1;
        for (int i = 0; i < DL; i++) begin
            @(negedge clk);
            checks++;
            if (hz.stallE !== 1'b1 || hz.div_done !== 1'b0) begin
                errors++;
                $display("FAIL div_stall_c%0d: got stallE=%b done=%b expected 1 0", i, hz.stallE, hz.div_done);
            end
            nextCycle();
        end
        @(negedge clk);
        checks++;
        if ({hz.div_done, hz.stallE, hz.div_busy} !== 3'b100) begin
            errors++;
            $display("FAIL div_done: got done/stallE/busy %b expected 100", {hz.div_done, hz.stallE, hz.div_busy});
        end
        nextCycle();
        hz.divE = 0;
        @(negedge clk);
        checks++;
        if ({hz.div_done, hz.div_busy, hz.stallE} !== 3'b000) begin
            errors++;
            $display("FAIL div_no_restart: got %b expected 000", {hz.div_done, hz.div_busy, hz.stallE});
        end
        nextCycle();
    endtask
    task automatic test_div_lwstall_memstall();
        clearInputs();
        hz.divE = 1;
        nextCycle();
        hz.memtoregE = 1; hz.writeregE = 6; hz.rsD = 6;
        @(negedge clk);
        checks++;
        if ({hz.flushE, hz.stallE, hz.div_busy} !== 3'b011) begin
            errors++;
            $display("FAIL div_lw: got flushE/stallE/busy %b expected 011", {hz.flushE, hz.stallE, hz.div_busy});
        end
        nextCycle();
        hz.memtoregE = 0; hz.mem_stall = 1;
        @(negedge clk);
        checks++;
        if ({hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW} !== 5'h1f) begin
            errors++;
            $display("FAIL div_memstall: got %b expected 11111", {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW});
        end
        nextCycle();
        hz.mem_stall = 0;
        nextCycle();
        @(negedge clk);
        checks++;
        if (hz.div_done !== 1'b1) begin
            errors++;
            $display("FAIL div_count_thru_memstall: got done=%b expected 1", hz.div_done);
        end
        hz.divE = 0;
        nextCycle();
    endtask
    task automatic test_exception();
        clearInputs();
        hz.divE = 1;
        nextCycle();
        hz.mem_stall = 1; hz.excM = 1;
        @(negedge clk);
        checks++;
        if (actual[12:2] !== 11'b00000_0000_1110 >> 0 && actual[12:2] !== 11'b000001110) begin
            errors++;
            $display("FAIL exc_controls: got stall/flush %b expected 000001110", actual[10:2]);
        end
        nextCycle();
        clearInputs();
        @(negedge clk);
        checks++;
        if ({hz.div_busy, hz.div_done} !== 2'b00) begin
            errors++;
            $display("FAIL exc_abort: got busy/done %b expected 00", {hz.div_busy, hz.div_done});
        end
        nextCycle();
    endtask
    task automatic test_reset_mid_busy();
        clearInputs();
        hz.divE = 1;
        nextCycle();
        hz.divE = 0;
        resetn = 0;
        #1;
        checks++;
        if (hz.div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b expected 0", hz.div_busy);
        end
        nextCycle();
        resetn = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({hz.div_busy, hz.div_done, hz.stallE} !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle_c%0d: got %b expected 000", i, {hz.div_busy, hz.div_done, hz.stallE});
            end
            nextCycle();
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            resetn = $urandom_range(0, 99) >= 3;
            hz.rsD = AW'($urandom_range(0, 3)); hz.rtD = AW'($urandom_range(0, 3));
            hz.rsE = AW'($urandom_range(0, 3)); hz.rtE = AW'($urandom_range(0, 3));
            hz.writeregE = AW'($urandom_range(0, 3)); hz.writeregM = AW'($urandom_range(0, 3));
            hz.writeregW = AW'($urandom_range(0, 3));
            {hz.branchD, hz.regwriteE, hz.memtoregE, hz.regwriteM, hz.memtoregM, hz.regwriteW} = 6'($urandom);
            hz.divE = $urandom_range(0, 99) < 40;
            hz.mem_stall = $urandom_range(0, 99) < 20;
            hz.excM = $urandom_range(0, 99) < 5;
            @(negedge clk);
            checks++;
            if (actual !== expected()) begin
                errors++;
                $display("FAIL random_c%0d: got %b expected %b", i, actual, expected());
            end
            nextCycle();
        end
        resetn = 1;
        clearInputs();
    endtask
    initial begin
        clearInputs();
        test_reset();
        test_forwarding();
        test_lwstall();
        test_div_sequence();
        test_div_lwstall_memstall();
        test_exception();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DIV_LAT, default 32, divider busy cycles; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have inputs rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW  input  REG_AW  stage register addresses.
REQ-006 SHALL have inputs branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW  input  1  decoded stage controls (divE: E holds div/divu).
REQ-007 SHALL have inputs mem_stall  input  1  data memory not ready; and excM  input  1  exception taken in M.
REQ-008 SHALL have outputs forwardaD, forwardbD  output  1  M->D bypass selects.
REQ-009 SHALL have outputs forwardaE, forwardbE  output  2  E bypass selects: 00 regfile, 01 W, 10 M.
REQ-010 SHALL have outputs stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW  output  1  pipeline-register controls.
REQ-011 SHALL have outputs div_busy  output  1  divider occupying E; and div_done  output  1  one-cycle result-valid pulse.

Function
REQ-012 forwardaD SHALL be 1 iff rsD!=0 & rsD==writeregM & regwriteM; forwardbD likewise with rtD.
REQ-013 forwardaE SHALL be 10 if rsE!=0 & rsE==writeregM & regwriteM, else 01 if rsE!=0 & rsE==writeregW & regwriteW, else 00; M beats W; forwardbE likewise with rtE.
REQ-014 lwstall SHALL = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
REQ-015 brstall SHALL = branchD & ((regwriteE & writeregE!=0 & writeregE matches rsD or rtD) | (memtoregM & writeregM!=0 & writeregM matches rsD or rtD)).
REQ-016 FSM states SHALL be IDLE, BUSY, DONE, with 8-bit down-counter cnt.
REQ-017 IDLE: divE & ~excM -> BUSY, cnt=DIV_LAT-1; else stay.
REQ-018 BUSY: cnt decrements each cycle, including during mem_stall; at cnt==0 -> DONE.
REQ-019 DONE: unconditionally -> IDLE next cycle; divE high in DONE SHALL NOT restart the divider.
REQ-020 divstall SHALL = (IDLE & divE) | BUSY; div_busy SHALL = BUSY; div_done SHALL = DONE.
REQ-021 stallF = stallD SHALL = lwstall | brstall | divstall | mem_stall.
REQ-022 stallE SHALL = brstall | divstall | mem_stall; stallM = stallW = mem_stall.
REQ-023 flushE SHALL = (lwstall | brstall) & ~divstall & ~mem_stall; stalled and flushed never both 1 for one stage.
REQ-024 flushD, flushM, flushW SHALL be 0 except under excM.
REQ-025 excM SHALL have highest priority: all stall* = 0; flushD = flushE = flushM = 1; flushW = 0; next state IDLE, cnt=0, regardless of mem_stall or FSM state.
REQ-026 All outputs except FSM-derived ones SHALL be combinational in current-cycle inputs; FSM adds no latency to stall assertion.

Reset
REQ-027 While resetn=0: state IDLE, cnt 0, div_busy 0, div_done 0, asynchronously.
REQ-028 Reset mid-BUSY SHALL abandon the divide; first cycle after release behaves as IDLE.
REQ-029 Combinational outputs SHALL follow inputs during reset; divstall contributes 0 unless divE.

Verification
REQ-030 rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=10; rsE=0 same -> 00.
REQ-031 memtoregE=1, writeregE=7, rtD=7 -> stallF=stallD=1, flushE=1, stallE=0; writeregE=0 -> all 0.
REQ-032 DIV_LAT=4, divE held high -> stallE=1 for 4 cycles (1 IDLE + 3 BUSY), div_done=1 in 5th cycle with stallE=0, then IDLE, no restart.
REQ-033 lwstall concurrent with BUSY -> flushE=0, stallE=1; mem_stall=1 in BUSY -> all stalls 1, cnt keeps counting.
REQ-034 excM=1 during BUSY with mem_stall=1 -> all stalls 0, flushD/E/M=1, flushW=0, next cycle IDLE, div_busy=0.
REQ-035 resetn low for 1 cycle mid-BUSY -> div_busy=0 immediately; after release with divE=0, state stays IDLE.
